// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute/decode-side bundle of the MDU controller.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_in_id;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_in_id,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_in_id,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi,lo}.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic [63:0] sa, sb;
  logic [31:0] ua, ub, uq, ur;
  logic        is_div;

  assign is_div      = (op == MDU_DIV) || (op == MDU_DIVU);
  assign div_by_zero = is_div && (b == 32'd0);

  always_comb begin
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = a;
    ub  = b;
    res = '0;
    if (op == MDU_DIV) begin
      ua = a[31] ? -a : a;
      ub = b[31] ? -b : b;
    end
    uq = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur = (ub == 32'd0) ? 32'd0 : ua % ub;
    unique case (1'b1)
      op == MDU_MULT:  res = sa * sb;
      op == MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      // 0x80000000 / -1 falls out of the magnitude path as 0x80000000 r 0
      op == MDU_DIV: begin
        res[31:0]  = (a[31] ^ b[31]) ? -uq : uq;
        res[63:32] = a[31] ? -ur : ur;
      end
      op == MDU_DIVU:  res = {ur, uq};
      default:         res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: FSM, busy countdown, operand latches, HI/LO.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] res;
  logic        dbz;

  mdu_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .res         (res),
    .div_by_zero (dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            bus.op <= MDU_DIVU: begin
              op_d    = bus.op;
              a_d     = bus.a;
              b_d     = bus.b;
              cnt_d   = bus.op[1] ? DIV_CNT : MULT_CNT;
              state_d = RUN;
            end
            bus.op == MDU_MTHI: hi_d = bus.a;
            bus.op == MDU_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (!dbz) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.stall_req = bus.md_in_id & (bus.busy | bus.start);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and latches the operands. It holds the HI/LO registers, runs a fixed-latency busy countdown per operation, and raises a stall request to the hazard unit while a decode-stage instruction needs the unit.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy duration for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, default 10: busy duration for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  execute stage holds an MDU instruction this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- a  in  32  rs operand.
- b  in  32  rt operand.
- md_in_id  in  1  decode stage holds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- busy  out  1  a multiply or divide is in flight.
- stall_req  out  1  stall request to the hazard unit: md_in_id & (busy | start).
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- Two states: IDLE and RUN. A 4-bit down-counter `cnt` drives the RUN state.
- In IDLE, start=1 with op 0..3:
  - latch a, b and op;
  - load `cnt` with MULT_CYCLES for ops 0..1, DIV_CYCLES for ops 2..3;
  - go to RUN.
- In IDLE, start=1 with op 4 writes hi<=a. Op 5 writes lo<=a. No busy is raised for either.
- In RUN, `cnt` decrements every cycle. On the edge where cnt==1:
  - commit the result to HI/LO;
  - clear `cnt`;
  - return to IDLE.
- In RUN, start is ignored for every op. The pipeline guarantees this through stall_req, and a bench violation has no effect.
- Result arithmetic, using the latched operands:
  - MULT: 64-bit signed product; {hi,lo} = product.
  - MULTU: 64-bit unsigned product; {hi,lo} = product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Division by zero: busy runs the full DIV_CYCLES, and HI/LO stay unchanged at commit.
- busy is 1 exactly when the state is RUN.
- stall_req is combinational from md_in_id, busy and start. It has no registered delay.
- Reset:
  - hi=0, lo=0, cnt=0, state=IDLE, busy=0;
  - stall_req follows its equation.
  - Reset in RUN aborts the operation; no commit occurs.
  - Reset overrides a simultaneous start.

## Timing
- start for MULT is sampled at edge T.
  - busy=1 during cycles T+1 through T+MULT_CYCLES.
  - hi/lo hold the new value from cycle T+MULT_CYCLES+1, the same cycle busy returns to 0.
- DIV timing is identical with DIV_CYCLES.
- MTHI/MTLO sampled at edge T: the new hi/lo value is visible from cycle T+1.
- A start in the cycle immediately after the commit cycle is accepted. There is no dead cycle between back-to-back operations.
- MFHI/MFLO read the hi/lo ports directly. Forwarding of the in-flight result is forbidden; stall_req covers that hazard.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings MDU_MULT..MDU_MTLO;
  - state encoding IDLE/RUN;
  - default latencies.
- One sub-module, `mdu_arith`:
  - purely combinational;
  - maps latched op, a and b to the 64-bit {hi_next, lo_next};
  - outputs a div_by_zero flag.
- The controller keeps the FSM, counter, operand latches and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3:
  - busy high for exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- Signed division:
  - DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles;
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero and write-during-busy:
  - MTHI a=0x1234 then MTLO a=0x5678 → hi=0x1234, lo=0x5678 one cycle after each;
  - DIVU b=0 → 10 busy cycles, hi/lo unchanged;
  - start=1, op=MTHI, a=0xAAAA during busy → ignored.
- Stall request:
  - md_in_id=1 throughout a MULT → stall_req=1 from the start cycle through the last busy cycle, and 0 in the commit-visible cycle;
  - md_in_id=0 → stall_req=0 throughout.
- Reset mid-DIV (cycle 4 of 10) → next cycle busy=0, hi=0, lo=0. A MULT started immediately afterward completes normally in 5 cycles.
